float_minmax_reduce: RTL

//  Streaming IEEE-754 min/max reduction: consumes a packet of 1..MAX_LEN floats over a

---
 rtl/float_pkg.sv | 48 ++++
 rtl/float_minmax_cmp.sv | 29 ++
 rtl/float_minmax_reduce.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/float_pkg.sv
// Shared definitions for the floating-point min/max reduction slice.
// W and CW are the single-precision, 256-element defaults. Configured instances derive
// their own widths from EXP_W, MAN_W and MAX_LEN.
// The helper functions take the format widths as arguments, which lets one package serve
// every precision. They handle formats up to 64 bits wide.
package float_pkg;

    localparam int W  = 32;   // 1 + 8 + 23
    localparam int CW = 9;    // $clog2(256) + 1

    // Reduction FSM: gather elements, then hold the result until it is taken
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // True for an all-ones exponent with a non-zero mantissa (quiet or signalling NaN)
    function automatic logic is_nan(input logic [63:0] x, input int exp_w, input int man_w);
        logic [63:0] exp_ones;
        logic [63:0] exp_field;
        logic [63:0] man_field;
        exp_ones  = (64'd1 << exp_w) - 64'd1;
        exp_field = (x >> man_w) & exp_ones;
        man_field = x & ((64'd1 << man_w) - 64'd1);
        return (exp_field == exp_ones) && (man_field != 64'd0);
    endfunction

    // Maps a float to an unsigned key whose integer order matches the float order.
    // Negative values reverse their magnitude order. Positive values move above all
    // negatives. The result puts -0 just below +0 and gives the infinities their
    // natural places.
    function automatic logic [63:0] ord_key(input logic [63:0] x, input int exp_w,
                                            input int man_w);
        int          w;
        logic [63:0] mask;
        logic [63:0] key;
        w    = 1 + exp_w + man_w;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        key  = x[w-1] ? ~x : (x ^ (64'd1 << (w - 1)));
        return key & mask;
    endfunction

    // Canonical quiet NaN: positive sign, all-ones exponent, only the top mantissa bit set
    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/float_minmax_cmp.sv
// Combinational comparator for the reduction.
// b_wins is strict: when two elements tie, the earlier one (a) is kept.
// b_nan flags a NaN on the incoming operand. NaN results are resolved by the caller.
module float_minmax_cmp
    import float_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int DW    = 1 + EXP_W + MAN_W
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          mode,     // 0 = max, 1 = min
    output logic          b_wins,
    output logic          b_nan
);

    logic [63:0] key_a;
    logic [63:0] key_b;

    // Order both operands by key, then pick the direction from mode
    always_comb begin
        key_a  = ord_key(64'(a), EXP_W, MAN_W);
        key_b  = ord_key(64'(b), EXP_W, MAN_W);
        b_wins = mode ? (key_b < key_a) : (key_b > key_a);
        b_nan  = is_nan(64'(b), EXP_W, MAN_W);
    end

endmodule

// File: rtl/float_minmax_reduce.sv
// Streaming IEEE-754 min/max reduction. The block takes 1..MAX_LEN elements per packet
// over a valid/ready stream and emits one registered result per packet.
// Any NaN in the packet forces the canonical quiet NaN.
// A packet that reaches MAX_LEN elements without in_last is closed and flagged as
// truncated.
// Optional feature: define ARGMAX_EN to add the z_idx port. It reports the index of the
// winning element, or of the first NaN.
module float_minmax_reduce
    import float_pkg::*;
#(
    parameter  int EXP_W   = 8,
    parameter  int MAN_W   = 23,
    parameter  int MAX_LEN = 256,
    localparam int DW      = 1 + EXP_W + MAN_W,
    localparam int CNT_W   = $clog2(MAX_LEN) + 1,
    localparam int IDX_W   = CNT_W - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic             in_last,
    output logic             z_valid,
    input  logic             z_ready,
    output logic [DW-1:0]    z_data,
    output logic [CNT_W-1:0] z_count,
    output logic             z_trunc
`ifdef ARGMAX_EN
    ,
    output logic [IDX_W-1:0] z_idx
`endif
);

    localparam logic [DW-1:0] CANON_NAN = DW'(canon_nan(EXP_W, MAN_W));

    state_t             state;
    logic [DW-1:0]      acc;        // current winner of the open packet
    logic               mode_r;     // direction latched with the first element
    logic               nan_r;      // sticky: a NaN was seen in the open packet
    logic [CNT_W-1:0]   cnt;        // elements accepted so far in the open packet

    logic               xfer;
    logic               first;
    logic               at_max;
    logic               close;
    logic [CNT_W-1:0]   cnt_inc;
    logic               b_wins;
    logic               b_nan;
    logic [DW-1:0]      next_acc;
    logic               next_nan;
    logic [DW-1:0]      result;

`ifdef ARGMAX_EN
    logic [IDX_W-1:0]   idx_r;      // index of the current winner
    logic [IDX_W-1:0]   elem_idx;
    logic [IDX_W-1:0]   next_idx;
`endif

    // In HOLD, in_ready drops through the state register. This leaves one bubble per packet.
    assign in_ready = (state == ACCUM);

    float_minmax_cmp #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_cmp (
        .a      (acc),
        .b      (in_data),
        .mode   (mode_r),
        .b_wins (b_wins),
        .b_nan  (b_nan)
    );

    // Next accumulator, NaN flag and result for an element accepted this cycle
    always_comb begin
        // NOTE: every signal gets a value before any branch, so no latch can be inferred.
        xfer     = in_valid & in_ready;
        first    = (cnt == '0);
        cnt_inc  = cnt + 1'b1;
        at_max   = (cnt_inc == CNT_W'(MAX_LEN));
        close    = xfer & (in_last | at_max);
        next_nan = first ? b_nan : (nan_r | b_nan);
        next_acc = (first | b_wins) ? in_data : acc;
        result   = next_nan ? CANON_NAN : next_acc;
    end

`ifdef ARGMAX_EN
    // Index of the winner; the first NaN pins the index for the rest of the packet
    always_comb begin
        elem_idx = cnt[IDX_W-1:0];
        next_idx = idx_r;
        if (first) begin
            next_idx = '0;
        end else if (!nan_r && (b_nan || b_wins)) begin
            next_idx = elem_idx;
        end
    end
`endif

    // Packet FSM with accumulator, counter and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACCUM;
            acc     <= '0;
            mode_r  <= 1'b0;
            nan_r   <= 1'b0;
            cnt     <= '0;
            z_valid <= 1'b0;
            z_data  <= '0;
            z_count <= '0;
            z_trunc <= 1'b0;
`ifdef ARGMAX_EN
            idx_r   <= '0;
            z_idx   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            case (state)
                ACCUM: begin
                    if (xfer) begin
                        if (first) begin
                            mode_r <= mode;
                        end
                        acc   <= next_acc;
                        nan_r <= next_nan;
`ifdef ARGMAX_EN
                        idx_r <= next_idx;
`endif
                        if (close) begin
                            cnt     <= '0;
                            state   <= HOLD;
                            z_valid <= 1'b1;
                            z_data  <= result;
                            z_count <= cnt_inc;
                            z_trunc <= ~in_last;
`ifdef ARGMAX_EN
                            z_idx   <= next_idx;
`endif
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                HOLD: begin
                    if (z_ready) begin
                        state   <= ACCUM;
                        z_valid <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
